// File: rtl/rgb_sram_writer.sv
// Purpose: clip 16.16 RGB accumulators to 8 bits, pack pixel pairs into three 16-bit words, write a frame to SRAM.
// Latency: word 0 one cycle after pixel 0 is accepted; words 1 and 2 one and two cycles after pixel 1; 5 cycles per pair minimum.
// Backpressure: pix_ready is high only in P0/P1; pix_valid outside those states is ignored, never queued.
module rgb_sram_writer #(
   parameter logic [17:0] RGB_BASE = 18'd146944,
   parameter int          PIXELS   = 76800
) (
   input  logic               CLOCK_50_I,
   input  logic               resetn,
   input  logic               start,
   input  logic               pix_valid,
   input  logic signed [31:0] R_acc,
   input  logic signed [31:0] G_acc,
   input  logic signed [31:0] B_acc,
   output logic               pix_ready,
   output logic [17:0]        SRAM_address,
   output logic [15:0]        SRAM_write_data,
   output logic               SRAM_we_n,
   output logic               busy,
   output logic               done
);

   localparam int           CW   = $clog2(PIXELS / 2 + 1);
   localparam logic [CW-1:0] LAST = CW'(PIXELS / 2 - 1);

   typedef enum logic [2:0] {IDLE, P0, W0, P1, W1, W2, DONE} state_t;

   state_t        state, next_state;
   logic [CW-1:0] pair_cnt, nxt_cnt;
   // Only the channels still needed after their capture cycle are kept:
   // B0 goes out in W1, G1/B1 in W2. R0, G0 and R1 are packed straight
   // from the clipped inputs on the accepting edge.
   logic [7:0]    b0, g1, b1;
   logic          nxt_ready, nxt_we_n, nxt_busy, nxt_done;
   logic [17:0]   nxt_addr;
   logic [15:0]   nxt_data;
   logic          accept, last_pair;
   logic [7:0]    r_clip, g_clip, b_clip;
   logic          unused_frac;

   // Saturate a signed 16.16 value to an unsigned 8-bit channel.
   function automatic logic [7:0] clip8(input logic [31:0] x);
      if (x[31])
         return 8'h00;
      else if (x[30:24] != 7'd0)
         return 8'hFF;
      else
         return x[23:16];
   endfunction

   assign accept      = pix_valid & pix_ready;
   assign last_pair   = (pair_cnt == LAST);
   assign r_clip      = clip8(R_acc);
   assign g_clip      = clip8(G_acc);
   assign b_clip      = clip8(B_acc);
   // Fraction bits are discarded by the clip.
   assign unused_frac = ^{R_acc[15:0], G_acc[15:0], B_acc[15:0]};

   // State register.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state decode: pixel states wait on a handshake, write states always advance.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start)  next_state = P0;
         P0:      if (accept) next_state = W0;
         W0:                  next_state = P1;
         P1:      if (accept) next_state = W1;
         W1:                  next_state = W2;
         W2:                  next_state = last_pair ? DONE : P0;
         DONE:                next_state = IDLE;
         default:             next_state = IDLE;
      endcase
   end

   // Next values of the registered outputs, address, data and pair counter.
   always_comb begin
      nxt_ready = (next_state == P0) || (next_state == P1);
      nxt_we_n  = !((next_state == W0) || (next_state == W1) || (next_state == W2));
      nxt_done  = (next_state == DONE);
      nxt_busy  = (next_state != IDLE);
      nxt_addr  = SRAM_address;
      nxt_data  = SRAM_write_data;
      nxt_cnt   = pair_cnt;
      case (state)
         IDLE: if (start) begin
            nxt_addr = RGB_BASE;
            nxt_cnt  = '0;
         end
         P0: if (accept) nxt_data = {r_clip, g_clip};
         W0: nxt_addr = SRAM_address + 18'd1;
         P1: if (accept) nxt_data = {b0, r_clip};
         W1: begin
            nxt_addr = SRAM_address + 18'd1;
            nxt_data = {g1, b1};
         end
         W2: begin
            nxt_addr = SRAM_address + 18'd1;
            if (!last_pair) nxt_cnt = pair_cnt + CW'(1);
         end
         default: ;
      endcase
   end

   // Output, datapath and pixel-channel registers.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         pix_ready       <= 1'b0;
         SRAM_we_n       <= 1'b1;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pair_cnt        <= '0;
         b0              <= '0;
         g1              <= '0;
         b1              <= '0;
      end else begin
         pix_ready       <= nxt_ready;
         SRAM_we_n       <= nxt_we_n;
         SRAM_address    <= nxt_addr;
         SRAM_write_data <= nxt_data;
         busy            <= nxt_busy;
         done            <= nxt_done;
         pair_cnt        <= nxt_cnt;
         if (state == P0 && accept) b0 <= b_clip;
         if (state == P1 && accept) begin
            g1 <= g_clip;
            b1 <= b_clip;
         end
      end
   end

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Bench for rgb_sram_writer with a 4-pixel frame: table of pixel pairs with
// hand-computed words, fed continuously, slowly, across a reset and with a
// stray start pulse.
module tb_rgb_sram_writer;

   localparam logic [17:0] BASE = 18'd146944;
   localparam int          NPIX = 4;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic               start = 1'b0;
   logic               pix_valid = 1'b0;
   logic signed [31:0] r_acc = '0, g_acc = '0, b_acc = '0;
   logic               pix_ready, we_n, busy, done;
   logic [17:0]        addr;
   logic [15:0]        wdata;

   always #10 clk = ~clk;

   rgb_sram_writer #(.RGB_BASE(BASE), .PIXELS(NPIX)) dut (
      .CLOCK_50_I     (clk),
      .resetn         (resetn),
      .start          (start),
      .pix_valid      (pix_valid),
      .R_acc          (r_acc),
      .G_acc          (g_acc),
      .B_acc          (b_acc),
      .pix_ready      (pix_ready),
      .SRAM_address   (addr),
      .SRAM_write_data(wdata),
      .SRAM_we_n      (we_n),
      .busy           (busy),
      .done           (done)
   );

   typedef struct {
      logic [31:0] r0, g0, b0, r1, g1, b1;
      logic [15:0] w0, w1, w2;
   } vec_t;
   vec_t tbl [4];

   int          n_cmp = 0, n_fail = 0;
   logic [17:0] wa_q[$];
   logic [15:0] wd_q[$];
   int          acc_cnt = 0, done_cnt = 0, viol_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Observe the write port and handshake mid-cycle.
   always @(negedge clk) begin
      if (resetn) begin
         if (!we_n) begin
            wa_q.push_back(addr);
            wd_q.push_back(wdata);
            if (pix_ready) viol_cnt++;
         end
         if (pix_valid && pix_ready) acc_cnt++;
         if (done) begin
            done_cnt++;
            chk("busy_with_done", 32'(busy), 32'd1);
         end
      end
   end

   task automatic clear_obs();
      wa_q.delete();
      wd_q.delete();
      acc_cnt  = 0;
      done_cnt = 0;
      viol_cnt = 0;
   endtask

   task automatic drive_junk();
      r_acc = $urandom;
      g_acc = $urandom;
      b_acc = $urandom;
   endtask

   task automatic drive_pix(input int p);
      int pr;
      pr = p / 2;
      if (p % 2 == 0) begin
         r_acc = tbl[pr].r0; g_acc = tbl[pr].g0; b_acc = tbl[pr].b0;
      end else begin
         r_acc = tbl[pr].r1; g_acc = tbl[pr].g1; b_acc = tbl[pr].b1;
      end
   endtask

   // Runs one frame of pairs p0, p0+1. mode 0: valid held high with junk
   // when not ready; mode 1: valid every 3rd cycle. inj pulses start in P1.
   // Called and returns at posedge+1.
   task automatic run_frame(input int p0, input int mode, input bit inj, input string tag);
      int   idx, cyc;
      bit   acc, injected, seen;
      logic [15:0] ew;
      idx = 0; cyc = 0; injected = 0; seen = 0;
      clear_obs();
      start     = 1'b1;
      pix_valid = (mode == 0);
      drive_junk();
      @(posedge clk); #1;
      start = 1'b0;
      while (idx < 4 && cyc < 200) begin
         pix_valid = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
         acc = pix_valid && pix_ready;
         if (acc) drive_pix(2 * p0 + idx); else drive_junk();
         if (inj && !injected && idx == 1 && pix_ready) begin
            start = 1'b1;
            injected = 1;
         end else
            start = 1'b0;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_feed_timeout"}, 32'(idx), 32'd4);
      for (int i = 0; i < 40 && !seen; i++) begin
         pix_valid = (mode == 0);
         drive_junk();
         if (done) seen = 1;
         @(posedge clk); #1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_done_after"}, 32'(done), 32'd0);
      repeat (4) begin
         drive_junk();
         @(posedge clk); #1;
      end
      chk({tag, "_ready_idle"}, 32'(pix_ready), 32'd0);
      pix_valid = 1'b0;
      chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'd6);
      for (int j = 0; j < 6; j++) begin
         case (j % 3)
            0:       ew = tbl[p0 + j / 3].w0;
            1:       ew = tbl[p0 + j / 3].w1;
            default: ew = tbl[p0 + j / 3].w2;
         endcase
         if (j < wa_q.size()) begin
            chk($sformatf("%s_addr%0d", tag, j), 32'(wa_q[j]), 32'(BASE + 18'(j)));
            chk($sformatf("%s_data%0d", tag, j), 32'(wd_q[j]), 32'(ew));
         end
      end
      chk({tag, "_accepts"}, 32'(acc_cnt), 32'd4);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_write_in_p"}, 32'(viol_cnt), 32'd0);
   endtask

   initial begin
      int  idx;
      bit  found, acc;

      tbl[0] = '{32'h007F_8000, 32'hFFFF_0000, 32'h0123_0000,
                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                 16'h7F00, 16'hFF00, 16'h0000};
      tbl[1] = '{32'h0012_0000, 32'h0034_0000, 32'h0056_0000,
                 32'h0078_0000, 32'h009A_0000, 32'h00BC_0000,
                 16'h1234, 16'h5678, 16'h9ABC};
      tbl[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h00AB_FFFF,
                 32'h0100_0000, 32'h00FF_0000, 32'hFFFF_FFFF,
                 16'h00FF, 16'hABFF, 16'hFF00};
      tbl[3] = '{32'h0001_0000, 32'h0000_FFFF, 32'h00FE_8000,
                 32'h0002_0000, 32'h4000_0000, 32'h00C3_1234,
                 16'h0100, 16'hFE02, 16'hFFC3};

      // Reset values.
      #35;
      chk("rst_ready", 32'(pix_ready), 32'd0);
      chk("rst_we_n",  32'(we_n),      32'd1);
      chk("rst_addr",  32'(addr),      32'd0);
      chk("rst_data",  32'(wdata),     32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      #10 resetn = 1'b1;
      @(posedge clk); #1;

      run_frame(0, 0, 1'b0, "bp");
      run_frame(2, 1, 1'b0, "slow");

      // Reset while in W1.
      clear_obs();
      idx = 0; found = 0;
      start = 1'b1;
      pix_valid = 1'b1;
      drive_junk();
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         if (!we_n && addr == BASE + 18'd1) found = 1;
         else begin
            acc = pix_ready;
            if (acc) drive_pix(idx); else drive_junk();
            @(posedge clk); #1;
            if (acc) idx++;
         end
      end
      chk("rst_reach_w1", 32'(found), 32'd1);
      #4 resetn = 1'b0;
      #1;
      chk("arst_we_n",  32'(we_n),      32'd1);
      chk("arst_addr",  32'(addr),      32'd0);
      chk("arst_busy",  32'(busy),      32'd0);
      chk("arst_ready", 32'(pix_ready), 32'd0);
      pix_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 resetn = 1'b1;
      @(posedge clk); #1;
      run_frame(0, 0, 1'b0, "restart");

      run_frame(2, 0, 1'b1, "start_busy");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
